alu16_pipe: RTL and testbench

- Two-stage registered pipeline wrapped around the 16-bit combinational datapath (adder, bitwise AND/OR/XOR/NOT, shifts).
- Captures operands and opcode via a valid/ready handshake and computes in stage 1.
- Registers the result plus status flags in stage 2.
- Presents them downstream on a valid/ready handshake with full backpressure.

---
 rtl/alu16_pkg.sv | 27 ++
 rtl/alu16_logic.sv | 81 ++++++++
 rtl/alu16_pipe.sv | 109 ++++++++++
 tb/tb_alu16_pipe.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu16_pkg.sv
// Shared definitions for the alu16 pipeline: opcode encoding, default
// datapath width and the bit positions of the status flags in the
// registered flag vector.
package alu16_pkg;

    localparam int unsigned ALU_WIDTH = 16;
    localparam int unsigned OP_W      = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } op_t;

    // Flag vector layout
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 3;
    localparam int unsigned FLAG_W = 4;

endpackage

// File: rtl/alu16_logic.sv
// Combinational ALU datapath: add/sub, bitwise, invert and 1-bit shifts,
// producing result s, carry/borrow c and signed overflow v.
// Optional macro ALU16_SAT_EN: ADD/SUB saturate to the signed range on
// overflow (v still reports the overflow, c is unaffected).
// Ports:
//   op  opcode (alu16_pkg::op_t encoding)
//   a,b operands (b unused by NOT/SHL/SHR)
//   s   result, c carry/borrow, v signed overflow
module alu16_logic
    import alu16_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             v
);

`ifdef ALU16_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    op_t              op_e;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;

    assign op_e  = op_t'(op);
    assign sum_w = {1'b0, a} + {1'b0, b};
    assign diff  = a - b;

    // Overflow: operand signs agree (add) / differ (sub) but result sign differs from a
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1]  != a[WIDTH-1]);

    // Result/flag select
    always_comb begin
        s = '0;
        c = 1'b0;
        v = 1'b0;
        case (op_e)
            OP_ADD: begin
                s = sum_w[WIDTH-1:0];
                c = sum_w[WIDTH];
                v = add_ovf;
            end
            OP_SUB: begin
                s = diff;
                c = (a < b);
                v = sub_ovf;
            end
            OP_AND: s = a & b;
            OP_OR:  s = a | b;
            OP_XOR: s = a ^ b;
            OP_NOT: s = ~a;
            OP_SHL: begin
                s = {a[WIDTH-2:0], 1'b0};
                c = a[WIDTH-1];
            end
            OP_SHR: begin
                s = {1'b0, a[WIDTH-1:1]};
                c = a[0];
            end
            default: s = '0;
        endcase
        // Overflow direction always follows the sign of a for both add and sub
        if (SAT_EN && v) begin
            s = a[WIDTH-1] ? S_MIN : S_MAX;
        end
    end

endmodule

// File: rtl/alu16_pipe.sv
// Two-stage pipelined 16-bit ALU with valid/ready on both sides.
// Stage 1 holds op/a/b and feeds the combinational datapath; stage 2
// holds the result and Z/N/C/V flags with full backpressure.
// Optional macro ALU16_SAT_EN: signed saturation on ADD/SUB.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   in_valid/in_ready            input handshake (in_ready is comb on out_ready)
//   in_op, in_a, in_b            opcode and operands
//   out_valid/out_ready          output handshake
//   out_s, out_z/n/c/v           result and flags
module alu16_pipe
    import alu16_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_z,
    output logic             out_n,
    output logic             out_c,
    output logic             out_v
);

    logic              s1_valid;
    logic [OP_W-1:0]   s1_op;
    logic [WIDTH-1:0]  s1_a;
    logic [WIDTH-1:0]  s1_b;
    logic              s2_valid;
    logic [WIDTH-1:0]  s2_s;
    logic [FLAG_W-1:0] s2_flags;

    logic              s1_adv;
    logic [WIDTH-1:0]  alu_s;
    logic              alu_c;
    logic              alu_v;
    logic [FLAG_W-1:0] alu_flags;

    // Stage 1 may move on when stage 2 is empty or is being drained this cycle
    assign s1_adv   = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s1_adv;

    alu16_logic #(
        .WIDTH (WIDTH)
    ) u_logic (
        .op (s1_op),
        .a  (s1_a),
        .b  (s1_b),
        .s  (alu_s),
        .c  (alu_c),
        .v  (alu_v)
    );

    // Flags taken from the final (possibly saturated) result
    always_comb begin
        alu_flags         = '0;
        alu_flags[FLAG_Z] = (alu_s == '0);
        alu_flags[FLAG_N] = alu_s[WIDTH-1];
        alu_flags[FLAG_C] = alu_c;
        alu_flags[FLAG_V] = alu_v;
    end

    // Stage 1: operand capture; refills or empties whenever it is ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op <= in_op;
                s1_a  <= in_a;
                s1_b  <= in_b;
            end
        end
    end

    // Stage 2: result/flags; held while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_s     <= '0;
            s2_flags <= '0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_s     <= alu_s;
                s2_flags <= alu_flags;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_s     = s2_s;
    assign out_z     = s2_flags[FLAG_Z];
    assign out_n     = s2_flags[FLAG_N];
    assign out_c     = s2_flags[FLAG_C];
    assign out_v     = s2_flags[FLAG_V];

endmodule

// File: tb/tb_alu16_pipe.sv
// Self-checking bench for alu16_pipe: directed vectors, back-to-back
// streaming, backpressure, random handshakes and mid-stream reset,
// all checked against an arithmetic reference model.
module tb_alu16_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_s;
    logic        out_z;
    logic        out_n;
    logic        out_c;
    logic        out_v;

    int checks = 0;
    int errors = 0;

    logic [19:0] obs;
    logic [19:0] exp_q[$];

    assign obs = {out_s, out_z, out_n, out_c, out_v};

    alu16_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_z     (out_z),
        .out_n     (out_n),
        .out_c     (out_c),
        .out_v     (out_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic; returns {s, z, n, c, v}
    function automatic logic [19:0] ref_model(input logic [2:0] op, input logic [15:0] a,
                                              input logic [15:0] b);
        int ia, ib, sa, sb, r, sr, s;
        logic c, v;
        ia = int'(a);
        ib = int'(b);
        sa = (ia >= 32768) ? ia - 65536 : ia;
        sb = (ib >= 32768) ? ib - 65536 : ib;
        c  = 1'b0;
        v  = 1'b0;
        sr = 0;
        case (op)
            3'd0: begin r = ia + ib; c = (r > 65535); sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
            3'd1: begin r = ia - ib; c = (ia < ib);   sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
            3'd2: r = ia & ib;
            3'd3: r = ia | ib;
            3'd4: r = ia ^ ib;
            3'd5: r = ~ia;
            3'd6: begin r = ia * 2; c = (ia >= 32768); end
            default: begin r = ia / 2; c = (ia % 2) == 1; end
        endcase
        s = r & 65535;
`ifdef ALU16_SAT_EN
        if (v) s = (sr > 0) ? 32767 : 32768;
`endif
        return {16'(s), (s == 0), (s >= 32768), c, v};
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || obs !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b obs=%h exp valid=0 obs=00000", out_valid, obs);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b exp 1", in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [2:0]  d_op [5];
        logic [15:0] d_a  [5];
        logic [15:0] d_b  [5];
        logic [19:0] d_exp[5];
        d_op = '{3'd0, 3'd1, 3'd1, 3'd5, 3'd6};
        d_a  = '{16'h7FFF, 16'h0003, 16'h0005, 16'h00FF, 16'h8001};
        d_b  = '{16'h0001, 16'h0005, 16'h0005, 16'h0000, 16'h0000};
`ifdef ALU16_SAT_EN
        d_exp[0] = {16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        d_exp[0] = {16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
        d_exp[1] = {16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0};
        d_exp[2] = {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
        d_exp[3] = {16'hFF00, 1'b0, 1'b1, 1'b0, 1'b0};
        d_exp[4] = {16'h0002, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            in_op     = d_op[i];
            in_a      = d_a[i];
            in_b      = d_b[i];
            out_ready = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_in_ready got %b exp 1", i, in_ready);
            end
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_early_valid got %b exp 0", i, out_valid);
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || obs !== d_exp[i]) begin
                errors++;
                $display("FAIL dir%0d_result got valid=%b obs=%h exp valid=1 obs=%h",
                         i, out_valid, obs, d_exp[i]);
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_drain got %b exp 0", i, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp_b[8];
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_in_ready cyc%0d got %b exp 1", k, in_ready);
            end
            if (k >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || obs !== exp_b[k-2]) begin
                    errors++;
                    $display("FAIL b2b_beat%0d got valid=%b obs=%h exp valid=1 obs=%h",
                             k - 2, out_valid, obs, exp_b[k-2]);
                end
            end
            if (k < 8) begin
                in_valid = 1'b1;
                in_op    = 3'($urandom_range(0, 7));
                in_a     = 16'($urandom);
                in_b     = 16'($urandom);
                exp_b[k] = ref_model(in_op, in_a, in_b);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [19:0] q[$];
        logic [19:0] held;
        int accepted;
        int popped;
        accepted  = 0;
        popped    = 0;
        held      = '0;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_op    = 3'($urandom_range(0, 7));
            in_a     = 16'($urandom);
            in_b     = 16'($urandom);
            #1;
            if (in_ready) begin
                accepted++;
                q.push_back(ref_model(in_op, in_a, in_b));
            end
            if (k == 2) held = obs;
            if (k == 3) begin
                checks++;
                if (out_valid !== 1'b1 || obs !== held) begin
                    errors++;
                    $display("FAIL bp_stall_stable got valid=%b obs=%h exp valid=1 obs=%h",
                             out_valid, obs, held);
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (accepted != 2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept_count got %0d ready=%b exp 2 ready=0", accepted, in_ready);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra_beat got obs=%h exp none", obs);
                end else begin
                    if (obs !== q[0]) begin
                        errors++;
                        $display("FAIL bp_order beat%0d got %h exp %h", popped, obs, q[0]);
                    end
                    void'(q.pop_front());
                    popped++;
                end
            end
            @(negedge clk);
        end
        checks++;
        if (popped != 2 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain got popped=%0d valid=%b exp 2 valid=0", popped, out_valid);
        end
    endtask

    task automatic test_random_handshake();
        logic        stall_prev;
        logic [19:0] held;
        stall_prev = 1'b0;
        held       = '0;
        exp_q.delete();
        for (int k = 0; k < 300; k++) begin
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || obs !== held) begin
                    errors++;
                    $display("FAIL rnd_stable cyc%0d got valid=%b obs=%h exp valid=1 obs=%h",
                             k, out_valid, obs, held);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_op     = 3'($urandom_range(0, 7));
            in_a      = 16'($urandom);
            in_b      = 16'($urandom);
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_spurious cyc%0d got obs=%h exp none", k, obs);
                end else begin
                    if (obs !== exp_q[0]) begin
                        errors++;
                        $display("FAIL rnd_data cyc%0d got %h exp %h", k, obs, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_model(in_op, in_a, in_b));
            stall_prev = out_valid && !out_ready;
            held       = obs;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_drain_spurious got obs=%h exp none", obs);
                end else begin
                    if (obs !== exp_q[0]) begin
                        errors++;
                        $display("FAIL rnd_drain_data got %h exp %h", obs, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rnd_lost_beats got pending=%0d valid=%b exp 0 valid=0",
                     exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        logic [19:0] exp_c;
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_op    = 3'd0;
            in_a     = 16'h1234 + 16'(k);
            in_b     = 16'h0101;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_full got valid=%b ready=%b exp valid=1 ready=0", out_valid, in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || obs !== 20'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_async got valid=%b obs=%h ready=%b exp valid=0 obs=00000 ready=1",
                     out_valid, obs, in_ready);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = 3'd4;
        in_a      = 16'hA5A5;
        in_b      = 16'h0FF0;
        exp_c     = ref_model(in_op, in_a, in_b);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_early got %b exp 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || obs !== exp_c) begin
            errors++;
            $display("FAIL rst_mid_first_beat got valid=%b obs=%h exp valid=1 obs=%h",
                     out_valid, obs, exp_c);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random_handshake();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
